// File: rtl/countdown_sequencer_if.sv
// Front-panel control/status bundle for the BCD countdown sequencer.
// master = key decoder side (drives controls), slave = sequencer.
interface countdown_sequencer_if;
    logic       load;
    logic [3:0] load_tens;
    logic [3:0] load_ones;
    logic       start;
    logic       hold;
    logic       abort;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [2:0] state;
    logic       busy;
    logic       ignite;

    modport master (
        output load, load_tens, load_ones, start, hold, abort,
        input  tens, ones, state, busy, ignite
    );

    modport slave (
        input  load, load_tens, load_ones, start, hold, abort,
        output tens, ones, state, busy, ignite
    );
endinterface

// File: rtl/countdown_sequencer.sv
// Two-digit BCD countdown controller: load preset, arm, prescaled countdown
// with hold/abort, one-cycle ignite pulse on reaching 00.
module countdown_sequencer #(
    parameter int TICK_DIV = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    countdown_sequencer_if.slave  bus
);
    localparam int             PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PMAX = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_COUNT   = 3'd2,
        S_PAUSED  = 3'd3,
        S_LAUNCH  = 3'd4,
        S_ABORTED = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ignite_q;

    logic [3:0]    ld_tens, ld_ones;
    logic          tick;
    logic          at_zero;
    logic          last_step;

    // Out-of-range BCD preset digits saturate at 9
    assign ld_tens   = (bus.load_tens > 4'd9) ? 4'd9 : bus.load_tens;
    assign ld_ones   = (bus.load_ones > 4'd9) ? 4'd9 : bus.load_ones;
    assign tick      = (state_q == S_COUNT) && (presc_q == PMAX);
    assign at_zero   = (tens_q == 4'd0) && (ones_q == 4'd0);
    assign last_step = (tens_q == 4'd0) && (ones_q == 4'd1);

    // Next-state, digit and prescaler logic; priority ABORT > HOLD > START > LOAD
    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ARMED;
                    presc_d = '0;
                end else if (bus.load) begin
                    tens_d = ld_tens;
                    ones_d = ld_ones;
                end
            end
            S_ARMED: begin
                if (bus.abort) begin
                    state_d = S_ABORTED;
                end else if (!bus.hold) begin
                    if (bus.start) begin
                        state_d = at_zero ? S_LAUNCH : S_COUNT;
                    end else if (bus.load) begin
                        tens_d = ld_tens;
                        ones_d = ld_ones;
                    end
                end
            end
            S_COUNT: begin
                // abort/hold discard a coincident tick and freeze the prescaler
                if (bus.abort) begin
                    state_d = S_ABORTED;
                end else if (bus.hold) begin
                    state_d = S_PAUSED;
                end else if (tick) begin
                    presc_d = '0;
                    if (ones_q != 4'd0) begin
                        ones_d = ones_q - 4'd1;
                    end else begin
                        ones_d = 4'd9;
                        tens_d = tens_q - 4'd1;
                    end
                    if (last_step) state_d = S_LAUNCH;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            S_PAUSED: begin
                if (bus.abort)                    state_d = S_ABORTED;
                else if (!bus.hold && bus.start)  state_d = S_COUNT;
            end
            S_LAUNCH, S_ABORTED: begin
                // a held abort keeps ABORTED; launch ignores abort entirely
                if (bus.load && !(state_q == S_ABORTED && bus.abort)) begin
                    state_d = S_IDLE;
                    tens_d  = ld_tens;
                    ones_d  = ld_ones;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, digits, prescaler and registered ignite pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
            presc_q  <= '0;
            ignite_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            presc_q  <= presc_d;
            ignite_q <= (state_d == S_LAUNCH) && (state_q != S_LAUNCH);
        end
    end

    assign bus.tens   = tens_q;
    assign bus.ones   = ones_q;
    assign bus.state  = state_q;
    assign bus.busy   = (state_q == S_COUNT) || (state_q == S_PAUSED);
    assign bus.ignite = ignite_q;
endmodule

// File: tb/tb_countdown_sequencer.sv
// Self-checking bench for countdown_sequencer with an integer-valued
// behavioural model (count held as 0..99, phase as a plain cycle counter).
module tb_countdown_sequencer;
    localparam int TICK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    countdown_sequencer_if bus ();

    countdown_sequencer #(.TICK_DIV(TICK)) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model: 0 idle,1 armed,2 count,3 paused,4 launch,5 aborted
    int m_state, m_val, m_ph;
    bit m_ign;

    task automatic model_reset();
        m_state = 0; m_val = 0; m_ph = 0; m_ign = 0;
    endtask

    task automatic model_step();
        int ns, nv, t, o;
        ns = m_state; nv = m_val;
        t  = (bus.load_tens > 9) ? 9 : int'(bus.load_tens);
        o  = (bus.load_ones > 9) ? 9 : int'(bus.load_ones);
        case (m_state)
            0: if (bus.start) begin ns = 1; m_ph = 0; end
               else if (bus.load) nv = t * 10 + o;
            1: if (bus.abort) ns = 5;
               else if (!bus.hold && bus.start) ns = (m_val == 0) ? 4 : 2;
               else if (!bus.hold && bus.load) nv = t * 10 + o;
            2: if (bus.abort) ns = 5;
               else if (bus.hold) ns = 3;
               else if (m_ph == TICK - 1) begin
                   m_ph = 0; nv = m_val - 1;
                   if (nv == 0) ns = 4;
               end else m_ph++;
            3: if (bus.abort) ns = 5;
               else if (!bus.hold && bus.start) ns = 2;
            4: if (bus.load) begin ns = 0; nv = t * 10 + o; end
            5: if (!bus.abort && bus.load) begin ns = 0; nv = t * 10 + o; end
            default: ns = 0;
        endcase
        m_ign   = (ns == 4) && (m_state != 4);
        m_state = ns;
        m_val   = nv;
    endtask

    function automatic logic [12:0] exp_vec();
        return {4'(m_val / 10), 4'(m_val % 10), 3'(m_state),
                (m_state == 2 || m_state == 3), m_ign};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {bus.tens, bus.ones, bus.state, bus.busy, bus.ignite};
    endfunction

    task automatic set_in(bit ld, logic [3:0] lt, logic [3:0] lo, bit st, bit hd, bit ab);
        bus.load = ld; bus.load_tens = lt; bus.load_ones = lo;
        bus.start = st; bus.hold = hd; bus.abort = ab;
    endtask

    // advance one clock; model follows the inputs seen at the edge
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_in(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            step();
            n_chk++;
            if (obs_vec() !== 13'h0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want 0000", i, obs_vec());
            end
        end
        set_in(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_countdown();
        int ign = 0;
        int e;
        set_in(1, 4'd1, 4'd2, 0, 0, 0); step();
        set_in(0, 0, 0, 1, 0, 0); step();
        n_chk++;
        if (bus.state !== 3'd1) begin n_fail++; $display("FAIL cd_armed: got %0d want 1", bus.state); end
        step();
        n_chk++;
        if (obs_vec() !== {4'd1, 4'd2, 3'd2, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL cd_count_entry: got %h want 12/COUNT", obs_vec());
        end
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 48; i++) begin
            step();
            ign += int'(bus.ignite);
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL cd_model cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i % 4 == 0 && i < 48) begin
                e = 12 - i / 4;
                n_chk++;
                if ({bus.tens, bus.ones} !== {4'(e / 10), 4'(e % 10)}) begin
                    n_fail++; $display("FAIL cd_digits cyc%0d: got %h%h want %0d", i, bus.tens, bus.ones, e);
                end
            end
        end
        n_chk++;
        if (bus.state !== 3'd4 || bus.ignite !== 1'b1) begin
            n_fail++; $display("FAIL cd_launch48: state %0d ignite %b want 4/1", bus.state, bus.ignite);
        end
        step();
        n_chk++;
        if (bus.ignite !== 1'b0 || ign != 1) begin
            n_fail++; $display("FAIL cd_pulse: ignite %b count %0d want 0/1", bus.ignite, ign);
        end
    endtask

    task automatic test_hold();
        int seen = 0;
        set_in(1, 4'd0, 4'd5, 0, 0, 0); step();
        set_in(0, 0, 0, 1, 0, 0); step(); step();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (8) step();
        set_in(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL hold_model cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        n_chk++;
        if (obs_vec() !== {4'd0, 4'd3, 3'd3, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL hold_frozen: got %h want 03/PAUSED", obs_vec());
        end
        set_in(0, 0, 0, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 20 && seen == 0; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL hold_resume cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
            if (bus.ignite === 1'b1) seen = i;
        end
        n_chk++;
        if (seen != 12) begin
            n_fail++; $display("FAIL hold_ignite_time: got %0d want 12 cycles after resume", seen);
        end
    endtask

    task automatic test_abort();
        set_in(1, 4'd1, 4'd0, 0, 0, 0); step();
        set_in(0, 0, 0, 1, 0, 0); step(); step();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (12) step();
        set_in(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            n_chk++;
            if (obs_vec() !== {4'd0, 4'd7, 3'd5, 1'b0, 1'b0} || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL abort_hold cyc%0d: got %h want 07/ABORTED", i, obs_vec());
            end
        end
        set_in(1, 4'd3, 4'd0, 0, 0, 0); step();
        n_chk++;
        if (obs_vec() !== {4'd3, 4'd0, 3'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL abort_reload: got %h want 30/IDLE", obs_vec());
        end
    endtask

    task automatic test_clamp_launch();
        int counted = 0, ign = 0;
        set_in(1, 4'hC, 4'hF, 0, 0, 0); step();
        n_chk++;
        if ({bus.tens, bus.ones} !== 8'h99) begin
            n_fail++; $display("FAIL clamp: got %h%h want 99", bus.tens, bus.ones);
        end
        set_in(1, 4'd0, 4'd0, 0, 0, 0); step();
        set_in(0, 0, 0, 1, 0, 0); step();
        set_in(0, 0, 0, 0, 0, 0); step();
        counted += int'(bus.state == 3'd2);
        set_in(0, 0, 0, 1, 0, 0); step();
        ign += int'(bus.ignite);
        n_chk++;
        if (obs_vec() !== {4'd0, 4'd0, 3'd4, 1'b0, 1'b1} || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL zero_launch: got %h want 00/LAUNCH/ignite", obs_vec());
        end
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) begin
            step();
            ign += int'(bus.ignite);
            counted += int'(bus.state == 3'd2);
        end
        n_chk++;
        if (ign != 1 || counted != 0 || bus.state !== 3'd4) begin
            n_fail++; $display("FAIL zero_pulse: ignites %0d count_cycles %0d state %0d want 1/0/4", ign, counted, bus.state);
        end
    endtask

    task automatic test_priority_reset();
        set_in(1, 4'd2, 4'd0, 0, 0, 0); step();
        set_in(0, 0, 0, 1, 0, 0); step(); step();
        set_in(0, 0, 0, 0, 0, 0); repeat (5) step();
        set_in(0, 0, 0, 1, 1, 1); step();
        n_chk++;
        if (bus.state !== 3'd5 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL all_pri: got %h want ABORTED %h", obs_vec(), exp_vec());
        end
        set_in(1, 4'd1, 4'd5, 0, 0, 0); step();
        set_in(0, 0, 0, 1, 0, 0); step(); step();
        set_in(0, 0, 0, 0, 0, 0); repeat (3) step();
        n_chk++;
        if (bus.state !== 3'd2 || bus.busy !== 1'b1) begin
            n_fail++; $display("FAIL pre_rst_count: state %0d busy %b want 2/1", bus.state, bus.busy);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++;
        if (obs_vec() !== 13'h0) begin
            n_fail++; $display("FAIL async_rst: got %h want 0000", obs_vec());
        end
        step();
        n_chk++;
        if (obs_vec() !== 13'h0) begin
            n_fail++; $display("FAIL rst_held: got %h want 0000", obs_vec());
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            set_in($urandom_range(0, 7) == 0, 4'($urandom), 4'($urandom),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                   $urandom_range(0, 39) == 0);
            step();
            n_chk++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        test_reset();
        test_countdown();
        test_hold();
        test_abort();
        test_clamp_launch();
        test_priority_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
